sblk_inst_dispatch: RTL and testbench

SBLK_INST_DISPATCH -- requirements
Module: sblk_inst_dispatch

---
 rtl/sblk_pkg.sv | 26 ++
 rtl/sblk_row_lock.sv | 34 +++
 rtl/sblk_inst_dispatch.sv | 116 +++++++++++
 tb/tb_sblk_inst_dispatch.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sblk_pkg.sv
// Shared types and defaults for the superblock instruction dispatcher.
// Holds the FSM states, row/word defaults and instruction field widths.
package sblk_pkg;

  localparam int N_ROW_DEF = 20;

  localparam int TN = 3;
  localparam int TM = 3;
  localparam int TP = 2;
  localparam int LN = 3;
  localparam int LP = 3;

  localparam int WID_INST_DEF = TN + TM + TP + LN + LP;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Never returns 0 so a zero lockout still yields a legal counter.
  function automatic int lock_w(input int cyc);
    return (cyc > 0) ? $clog2(cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/sblk_row_lock.sv
// Per-row lockout counter and issue eligibility.
// A row may issue when pending, not busy and its lockout has expired.
module sblk_row_lock
  import sblk_pkg::*;
#(
  parameter int LOCK_CYC = 2
) (
  input  logic clk_l,
  input  logic rst_n,
  input  logic pend,
  input  logic stat,
  input  logic issue_en,
  output logic elig,
  output logic idle
);

  localparam int LW = lock_w(LOCK_CYC);

  logic [LW-1:0] cnt;

  assign idle = (cnt == '0);
  assign elig = issue_en & pend & ~stat & idle;

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (elig) begin
      cnt <= LW'(LOCK_CYC);
    end else if (!idle) begin
      cnt <= cnt - LW'(1);
    end
  end

endmodule

// File: rtl/sblk_inst_dispatch.sv
// Broadcasts masked instructions to a row of superblocks.
// Issues every ready row at once, then optionally drains before done.
module sblk_inst_dispatch
  import sblk_pkg::*;
#(
  parameter int N_ROW    = N_ROW_DEF,
  parameter int WID_INST = WID_INST_DEF,
  parameter int LOCK_CYC = 2
) (
  input  logic                      clk_l,
  input  logic                      rst_n,
  input  logic [WID_INST-1:0]       cmd_data,
  input  logic [N_ROW-1:0]          cmd_mask,
  input  logic                      cmd_last,
  input  logic                      cmd_vld,
  output logic                      cmd_rdy,
  output logic [WID_INST*N_ROW-1:0] inst_data,
  output logic [N_ROW-1:0]          inst_en,
  input  logic [N_ROW-1:0]          status_sblk,
  output logic                      busy,
  output logic                      done,
  output logic                      err_mask
);

  state_t st, st_nxt;

  logic                rdy_q;
  logic [WID_INST-1:0] data_q;
  logic                last_q;
  logic [N_ROW-1:0]    pend;
  logic [N_ROW-1:0]    elig;
  logic [N_ROW-1:0]    lk_idle;
  logic                hs;
  logic                issue_en;
  logic                drain_ok;

  // rdy_q keeps cmd_rdy low until the first clock out of reset.
  assign cmd_rdy  = rdy_q & (st == ST_IDLE);
  assign busy     = (st != ST_IDLE);
  assign hs       = cmd_vld & cmd_rdy;
  assign issue_en = (st == ST_ISSUE);
  assign drain_ok = (status_sblk == '0) && (&lk_idle);

  for (genvar r = 0; r < N_ROW; r++) begin : g_row
    sblk_row_lock #(
      .LOCK_CYC(LOCK_CYC)
    ) u_lock (
      .clk_l   (clk_l),
      .rst_n   (rst_n),
      .pend    (pend[r]),
      .stat    (status_sblk[r]),
      .issue_en(issue_en),
      .elig    (elig[r]),
      .idle    (lk_idle[r])
    );
  end

  always_comb begin
    st_nxt = st;
    unique case (1'b1)
      st == ST_IDLE: begin
        if (hs) begin
          if (cmd_mask == '0) begin
            st_nxt = cmd_last ? ST_DRAIN : ST_IDLE;
          end else begin
            st_nxt = ST_ISSUE;
          end
        end
      end
      st == ST_ISSUE: begin
        if ((pend & ~elig) == '0) begin
          st_nxt = last_q ? ST_DRAIN : ST_IDLE;
        end
      end
      st == ST_DRAIN: begin
        if (drain_ok) begin
          st_nxt = ST_IDLE;
        end
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      rdy_q    <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      pend     <= '0;
      inst_en  <= '0;
      inst_data <= '0;
      done     <= 1'b0;
      err_mask <= 1'b0;
    end else begin
      st       <= st_nxt;
      rdy_q    <= 1'b1;
      inst_en  <= elig;
      done     <= (st == ST_DRAIN) && drain_ok;
      err_mask <= hs && (cmd_mask == '0);
      if (hs) begin
        data_q <= cmd_data;
        last_q <= cmd_last;
        pend   <= cmd_mask;
      end else begin
        pend <= pend & ~elig;
      end
      for (int r = 0; r < N_ROW; r++) begin
        if (elig[r]) begin
          inst_data[r*WID_INST +: WID_INST] <= data_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_sblk_inst_dispatch.sv
// Directed self-checking bench for sblk_inst_dispatch.
// Each task drives one scenario and checks against hand-computed values.
module tb_sblk_inst_dispatch;

  localparam int NR = 20;
  localparam int WI = 14;
  localparam int LC = 2;

  logic             clk_l = 1'b0;
  logic             rst_n;
  logic [WI-1:0]    cmd_data;
  logic [NR-1:0]    cmd_mask;
  logic             cmd_last;
  logic             cmd_vld;
  logic             cmd_rdy;
  logic [WI*NR-1:0] inst_data;
  logic [NR-1:0]    inst_en;
  logic [NR-1:0]    status_sblk;
  logic             busy;
  logic             done;
  logic             err_mask;

  int n_run  = 0;
  int n_fail = 0;

  sblk_inst_dispatch #(
    .N_ROW   (NR),
    .WID_INST(WI),
    .LOCK_CYC(LC)
  ) dut (
    .clk_l      (clk_l),
    .rst_n      (rst_n),
    .cmd_data   (cmd_data),
    .cmd_mask   (cmd_mask),
    .cmd_last   (cmd_last),
    .cmd_vld    (cmd_vld),
    .cmd_rdy    (cmd_rdy),
    .inst_data  (inst_data),
    .inst_en    (inst_en),
    .status_sblk(status_sblk),
    .busy       (busy),
    .done       (done),
    .err_mask   (err_mask)
  );

  always #5 clk_l = ~clk_l;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_l);
    #1;
  endtask

  function automatic logic [WI-1:0] slice(input int r);
    return inst_data[r*WI +: WI];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_data = '0;
    cmd_mask = '0;
    cmd_last = 1'b0;
    cmd_vld = 1'b0;
    status_sblk = '0;
    #3;
    n_run++;
    if ({cmd_rdy, busy, done, err_mask} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 0000",
               {cmd_rdy, busy, done, err_mask});
    end
    n_run++;
    if (inst_en !== '0 || inst_data !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got en=%h data=%h want 0",
               inst_en, inst_data);
    end
    step();
    step();
    rst_n = 1'b1;
    #1;
    n_run++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_pre_clk: got %b want 0", cmd_rdy);
    end
    step();
    n_run++;
    if (cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rdy_rise: got %b want 1", cmd_rdy);
    end
  endtask

  task automatic test_basic();
    int k;
    cmd_data = 14'h1ABC;
    cmd_mask = 20'h0000F;
    cmd_last = 1'b1;
    cmd_vld = 1'b1;
    step();
    cmd_vld = 1'b0;
    n_run++;
    if ({busy, cmd_rdy} !== 2'b10 || inst_en !== '0) begin
      n_fail++;
      $display("FAIL basic_accept: got busy=%b rdy=%b en=%h want 1 0 0",
               busy, cmd_rdy, inst_en);
    end
    step();
    n_run++;
    if (inst_en !== 20'h0000F) begin
      n_fail++;
      $display("FAIL basic_en: got %h want 0000f", inst_en);
    end
    n_run++;
    if (slice(0) !== 14'h1ABC || slice(3) !== 14'h1ABC ||
        slice(4) !== 14'h0000) begin
      n_fail++;
      $display("FAIL basic_data: got %h %h %h want 1abc 1abc 0000",
               slice(0), slice(3), slice(4));
    end
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
    n_run++;
    if (k != LC + 1) begin
      n_fail++;
      $display("FAIL basic_done_lat: got %0d want %0d", k, LC + 1);
    end
    step();
    n_run++;
    if ({done, busy, cmd_rdy} !== 3'b001) begin
      n_fail++;
      $display("FAIL basic_after: got %b want 001", {done, busy, cmd_rdy});
    end
  endtask

  task automatic test_stall();
    logic bad;
    cmd_data = 14'h0555;
    cmd_mask = 20'h00003;
    cmd_last = 1'b0;
    cmd_vld = 1'b1;
    status_sblk = 20'h00002;
    step();
    cmd_vld = 1'b0;
    step();
    n_run++;
    if (inst_en !== 20'h00001 || cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_row0: got en=%h rdy=%b want 00001 0",
               inst_en, cmd_rdy);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (inst_en !== '0 || cmd_rdy !== 1'b0) bad = 1'b1;
    end
    n_run++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: got early issue/rdy want none");
    end
    status_sblk = '0;
    step();
    n_run++;
    if (inst_en !== 20'h00002 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_row1: got en=%h rdy=%b want 00002 1",
               inst_en, cmd_rdy);
    end
    n_run++;
    if (slice(1) !== 14'h0555 || slice(0) !== 14'h0555 ||
        slice(2) !== 14'h1ABC) begin
      n_fail++;
      $display("FAIL stall_data: got %h %h %h want 0555 0555 1abc",
               slice(0), slice(1), slice(2));
    end
    step();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    int k;
    cmd_data = 14'h0011;
    cmd_mask = 20'h00001;
    cmd_last = 1'b0;
    cmd_vld = 1'b1;
    step();
    cmd_data = 14'h2222;
    step();
    n_run++;
    if (inst_en !== 20'h00001 || slice(0) !== 14'h0011) begin
      n_fail++;
      $display("FAIL b2b_first: got en=%h d=%h want 00001 0011",
               inst_en, slice(0));
    end
    step();
    cmd_vld = 1'b0;
    k = 0;
    for (int i = 2; i <= 12; i++) begin
      step();
      if (inst_en[0] === 1'b1) begin
        k = i;
        break;
      end
    end
    n_run++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d want 3", k);
    end
    n_run++;
    if (slice(0) !== 14'h2222) begin
      n_fail++;
      $display("FAIL b2b_data: got %h want 2222", slice(0));
    end
    step();
    step();
    step();
  endtask

  task automatic test_zero_mask();
    cmd_mask = '0;
    cmd_last = 1'b0;
    cmd_data = 14'h3FFF;
    cmd_vld = 1'b1;
    step();
    cmd_vld = 1'b0;
    n_run++;
    if ({err_mask, cmd_rdy, busy} !== 3'b110 || inst_en !== '0) begin
      n_fail++;
      $display("FAIL zmask: got err=%b rdy=%b busy=%b en=%h want 1 1 0 0",
               err_mask, cmd_rdy, busy, inst_en);
    end
    step();
    n_run++;
    if (err_mask !== 1'b0) begin
      n_fail++;
      $display("FAIL zmask_pulse: got %b want 0", err_mask);
    end
    cmd_last = 1'b1;
    cmd_vld = 1'b1;
    step();
    cmd_vld = 1'b0;
    n_run++;
    if ({err_mask, busy, done} !== 3'b110) begin
      n_fail++;
      $display("FAIL zmask_last: got %b want 110", {err_mask, busy, done});
    end
    step();
    n_run++;
    if ({done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL zmask_done: got %b want 10", {done, busy});
    end
    n_run++;
    if (slice(0) !== 14'h2222) begin
      n_fail++;
      $display("FAIL zmask_nodata: got %h want 2222", slice(0));
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic bad;
    cmd_data = 14'h0777;
    cmd_mask = 20'h000FF;
    cmd_last = 1'b1;
    cmd_vld = 1'b1;
    status_sblk = 20'h000F0;
    step();
    cmd_vld = 1'b0;
    step();
    n_run++;
    if (inst_en !== 20'h0000F || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_issue: got en=%h busy=%b want 0000f 1",
               inst_en, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (inst_en !== '0 || inst_data !== '0 ||
        {busy, cmd_rdy, done, err_mask} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_rst: got en=%h busy=%b rdy=%b want 0 0 0",
               inst_en, busy, cmd_rdy);
    end
    status_sblk = '0;
    #2;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (inst_en !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    n_run++;
    if (bad !== 1'b0 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_after: got bad=%b rdy=%b want 0 1", bad, cmd_rdy);
    end
  endtask

  task automatic test_drain_stall();
    logic bad;
    int k;
    cmd_data = 14'h1234;
    cmd_mask = 20'h80000;
    cmd_last = 1'b1;
    cmd_vld = 1'b1;
    status_sblk = '0;
    step();
    cmd_vld = 1'b0;
    step();
    n_run++;
    if (inst_en !== 20'h80000 || slice(19) !== 14'h1234) begin
      n_fail++;
      $display("FAIL drain_issue: got en=%h d=%h want 80000 1234",
               inst_en, slice(19));
    end
    status_sblk = 20'h80000;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    n_run++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_hold: got early done want none");
    end
    status_sblk = '0;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
    n_run++;
    if (k != 1) begin
      n_fail++;
      $display("FAIL drain_done: got %0d want 1", k);
    end
    step();
    n_run++;
    if ({done, busy, cmd_rdy} !== 3'b001) begin
      n_fail++;
      $display("FAIL drain_idle: got %b want 001", {done, busy, cmd_rdy});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_zero_mask();
    test_reset_mid();
    test_drain_stall();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
